// File: rtl/shift_fifo_pkg.sv
// shift_fifo_pkg
//   Shared definitions for the shift-register FIFO slice: default geometry,
//   the occupancy-counter width helper and the default data word type.
package shift_fifo_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_DEPTH = 8;

   // Occupancy counter must hold 0..depth inclusive, hence one extra bit.
   function automatic int pc_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef logic [DEF_WIDTH-1:0] word_t;

endpackage

// File: rtl/shift_fifo_ctrl_if.sv
// shift_fifo_ctrl_if
//   Handshake/data bundle between a producer/consumer and the FIFO.
//   master : drives push, pop, D_in; observes Data_out, pc, full, empty
//   slave  : the FIFO side (directions reversed)
//   When FIFO_ERR_FLAGS_EN is defined the bundle also carries the sticky
//   overflow/underflow flags driven by the FIFO.
interface shift_fifo_ctrl_if
   import shift_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) ();

   localparam int PCW = pc_width(DEPTH);

   logic             push;
   logic             pop;
   logic [WIDTH-1:0] D_in;
   logic [WIDTH-1:0] Data_out;
   logic [PCW-1:0]   pc;
   logic             full;
   logic             empty;
`ifdef FIFO_ERR_FLAGS_EN
   logic             overflow;
   logic             underflow;

   modport master (
      output push, pop, D_in,
      input  Data_out, pc, full, empty, overflow, underflow
   );

   modport slave (
      input  push, pop, D_in,
      output Data_out, pc, full, empty, overflow, underflow
   );
`else
   modport master (
      output push, pop, D_in,
      input  Data_out, pc, full, empty
   );

   modport slave (
      input  push, pop, D_in,
      output Data_out, pc, full, empty
   );
`endif

endinterface

// File: rtl/shift_store.sv
// shift_store
//   DEPTH x WIDTH serial-in register chain. Newest word enters at entry 0,
//   every shift moves each entry one slot deeper; the last slot falls off.
//   Ports:
//     clk      - system clock
//     reset    - synchronous active-low clear of every entry
//     shift_en - load D_in into entry 0 and shift the chain
//     D_in     - word to insert
//     entries  - all storage entries, index 0 = newest
module shift_store
   import shift_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        shift_en,
   input  logic [WIDTH-1:0]            D_in,
   output logic [DEPTH-1:0][WIDTH-1:0] entries
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         entries <= '0;
      end else if (shift_en) begin
         entries[0] <= D_in;
         for (int i = 1; i < DEPTH; i++) begin
            entries[i] <= entries[i-1];
         end
      end
   end

endmodule

// File: rtl/shift_fifo_ctrl.sv
// shift_fifo_ctrl
//   Shift-register FIFO: occupancy controller, serial-in register chain
//   (shift_store) and a read mux that presents the oldest entry.
//   Ports:
//     clk   - system clock, all state updates on the rising edge
//     reset - synchronous active-low reset, clears pc and all storage
//     bus   - shift_fifo_ctrl_if.slave: push/pop/D_in in,
//             Data_out/pc/full/empty out
//   Optional build macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
//   flags on the bus, cleared only by reset.
module shift_fifo_ctrl
   import shift_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int PCW   = pc_width(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   shift_fifo_ctrl_if.slave bus
);

   logic [PCW-1:0]              pc_q;
   logic [PCW-1:0]              pc_d;
   logic                        full;
   logic                        empty;
   logic                        shift_en;
   logic [DEPTH-1:0][WIDTH-1:0] entries;
   logic [WIDTH-1:0]            data_out;

   assign full  = (pc_q == PCW'(DEPTH));
   assign empty = (pc_q == '0);

   // A push is accepted when there is room, or when a simultaneous pop
   // frees the slot that the shift pushes off the end of the chain.
   assign shift_en = bus.push && (!full || bus.pop);

   always_comb begin
      pc_d = pc_q;
      unique case ({bus.push, bus.pop})
         2'b10: if (!full)  pc_d = pc_q + PCW'(1);
         2'b01: if (!empty) pc_d = pc_q - PCW'(1);
         // Push+pop on an empty FIFO has nothing to pop: acts as push only.
         2'b11: if (empty)  pc_d = PCW'(1);
         default: pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   shift_store #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_store (
      .clk      (clk),
      .reset    (reset),
      .shift_en (shift_en),
      .D_in     (bus.D_in),
      .entries  (entries)
   );

   // Oldest entry sits at index pc-1; a popped word is left in the chain
   // and simply falls outside the pc window.
   always_comb begin
      data_out = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (pc_q == PCW'(i + 1)) data_out = entries[i];
      end
   end

   assign bus.Data_out = data_out;
   assign bus.pc       = pc_q;
   assign bus.full     = full;
   assign bus.empty    = empty;

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q;
   logic underflow_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.push && full && !bus.pop) overflow_q  <= 1'b1;
         if (bus.pop && empty)             underflow_q <= 1'b1;
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_shift_fifo_ctrl.sv
// tb_shift_fifo_ctrl
//   Directed bench for shift_fifo_ctrl. A queue model (oldest at front) is
//   compared with the DUT on every falling edge; literal expectations at
//   key points pin the model to hand-computed values.
module tb_shift_fifo_ctrl;
   import shift_fifo_pkg::*;

   localparam int WIDTH = 4;
   localparam int DEPTH = 8;
   localparam int PCW   = pc_width(DEPTH);

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   shift_fifo_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   shift_fifo_ctrl #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .PCW   (PCW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   int q[$];
   bit m_ovf = 1'b0;
   bit m_udf = 1'b0;
   bit model_valid = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: pop removes the front, push appends at the back.
   always @(posedge clk) begin
      if (!reset) begin
         q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         bit do_pop;
         bit do_push;
         do_pop  = bus.pop && (q.size() > 0);
         do_push = bus.push && ((q.size() < DEPTH) || bus.pop);
         if (bus.push && !bus.pop && q.size() == DEPTH) m_ovf = 1'b1;
         if (bus.pop && q.size() == 0)                  m_udf = 1'b1;
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back(int'(bus.D_in));
      end
      model_valid = 1'b1;
   end

   always @(negedge clk) begin
      if (model_valid) begin
         chk("cmp_data",  32'(bus.Data_out), (q.size() > 0) ? 32'(q[0]) : 32'd0);
         chk("cmp_pc",    32'(bus.pc),       32'(q.size()));
         chk("cmp_full",  32'(bus.full),     32'(q.size() == DEPTH));
         chk("cmp_empty", 32'(bus.empty),    32'(q.size() == 0));
`ifdef FIFO_ERR_FLAGS_EN
         chk("cmp_ovf",   32'(bus.overflow),  32'(m_ovf));
         chk("cmp_udf",   32'(bus.underflow), 32'(m_udf));
`endif
      end
   end

   task automatic cyc(input logic r, input logic pu, input logic po, input logic [WIDTH-1:0] d);
      reset    = r;
      bus.push = pu;
      bus.pop  = po;
      bus.D_in = d;
      @(posedge clk);
      #2;
   endtask

   initial begin
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      bus.D_in = '0;

      // Reset dominates a push
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 4'd5);
         chk("rst_pc",    32'(bus.pc),       32'd0);
         chk("rst_empty", 32'(bus.empty),    32'd1);
         chk("rst_full",  32'(bus.full),     32'd0);
         chk("rst_data",  32'(bus.Data_out), 32'd0);
      end

      // Fill 1..8, head stays 1
      for (int k = 1; k <= 8; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 4'(k));
         chk("fill_pc",   32'(bus.pc),       32'(k));
         chk("fill_data", 32'(bus.Data_out), 32'd1);
      end
      chk("fill_full", 32'(bus.full), 32'd1);

      // Push into full FIFO is dropped
      cyc(1'b1, 1'b1, 1'b0, 4'd9);
      chk("ovf_pc",   32'(bus.pc),       32'd8);
      chk("ovf_data", 32'(bus.Data_out), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
      chk("ovf_flag", 32'(bus.overflow), 32'd1);
`endif

      // Drain in order
      for (int k = 1; k <= 8; k++) begin
         chk("drain_data", 32'(bus.Data_out), 32'(k));
         cyc(1'b1, 1'b0, 1'b1, 4'd0);
      end
      chk("drain_end_data",  32'(bus.Data_out), 32'd0);
      chk("drain_end_empty", 32'(bus.empty),    32'd1);

      // Full push+pop: oldest discarded, new word enters
      for (int k = 1; k <= 8; k++) cyc(1'b1, 1'b1, 1'b0, 4'(k));
      cyc(1'b1, 1'b1, 1'b1, 4'd9);
      chk("fullpp_pc",   32'(bus.pc),       32'd8);
      chk("fullpp_data", 32'(bus.Data_out), 32'd2);

      // Reset, then 3,4 with simultaneous push 7 + pop
      cyc(1'b0, 1'b0, 1'b0, 4'd0);
      cyc(1'b1, 1'b1, 1'b0, 4'd3);
      cyc(1'b1, 1'b1, 1'b0, 4'd4);
      cyc(1'b1, 1'b1, 1'b1, 4'd7);
      chk("simul_pc",   32'(bus.pc),       32'd2);
      chk("simul_data", 32'(bus.Data_out), 32'd4);
      cyc(1'b1, 1'b0, 1'b1, 4'd0);
      chk("simul_next", 32'(bus.Data_out), 32'd7);
      cyc(1'b1, 1'b0, 1'b1, 4'd0);

      // Pop while empty
      cyc(1'b1, 1'b0, 1'b1, 4'd0);
      chk("udf_pc",   32'(bus.pc),       32'd0);
      chk("udf_data", 32'(bus.Data_out), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
      chk("udf_flag", 32'(bus.underflow), 32'd1);
`endif

      // Push+pop while empty acts as push
      cyc(1'b1, 1'b1, 1'b1, 4'd6);
      chk("emptypp_pc",   32'(bus.pc),       32'd1);
      chk("emptypp_data", 32'(bus.Data_out), 32'd6);

      // Mid-operation reset at pc = 5
      for (int k = 1; k <= 4; k++) cyc(1'b1, 1'b1, 1'b0, 4'(k + 10));
      chk("mid_pc_before", 32'(bus.pc), 32'd5);
      cyc(1'b0, 1'b0, 1'b0, 4'd0);
      chk("mid_pc",   32'(bus.pc),       32'd0);
      chk("mid_data", 32'(bus.Data_out), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
      chk("mid_udf", 32'(bus.underflow), 32'd0);
`endif
      cyc(1'b1, 1'b1, 1'b0, 4'd3);
      chk("post_pc",   32'(bus.pc),       32'd1);
      chk("post_data", 32'(bus.Data_out), 32'd3);

      cyc(1'b1, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
